// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing helpers: state encoding and ns-to-cycle derivations.
// Also used by the servo PWM generator so both ends agree on the pulse timebase.
package servo_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_WAIT = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  localparam int unsigned MS_NS = 1_000_000;

  function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned clk_per_ns);
    return ns / clk_per_ns;
  endfunction

  function automatic int unsigned ms_cyc(input int unsigned clk_per_ns);
    return MS_NS / clk_per_ns;
  endfunction

  function automatic int unsigned step_cyc(input int unsigned step_ns, input int unsigned clk_per_ns);
    return step_ns / clk_per_ns;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/servo_pulse_decoder_input_sync.sv
// servo_input_sync: 2-FF synchronizer, optional 3-sample filter (SERVO_DEC_GLITCH_FILTER_EN), edge detect.
// level_o follows srv_i by 2 cycles (4 with filter); rise_o/fall_o are registered one cycle later.
module servo_input_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic srv_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q, rise_q, fall_q;
  logic level;

`ifdef SERVO_DEC_GLITCH_FILTER_EN
  logic h1_q, h2_q, filt_q;
  logic agree;

  assign agree = (s2_q == h1_q) && (h1_q == h2_q);
  assign level = agree ? s2_q : filt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h1_q   <= 1'b1;
      h2_q   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      h1_q   <= s2_q;
      h2_q   <= h1_q;
      filt_q <= level;
    end
  end
`else
  assign level = s2_q;
`endif

  // Chain resets high so a line already high at reset release never yields a rise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= srv_i;
      s2_q   <= s1_q;
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  assign level_o = level;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures srv_i high time into an N-bit code, flags too-long pulses and signal loss.
// valid_o 4 cycles after srv_i fall (6 with SERVO_DEC_GLITCH_FILTER_EN); no backpressure, strobes only.
module servo_pulse_decoder
  import servo_pulse_decoder_pkg::*;
#(
  parameter int unsigned CLK_PER_NS   = 40,
  parameter int unsigned N            = 8,
  parameter int unsigned STEP_NS      = 4000,
  parameter int unsigned MIN_PULSE_NS = 500_000,
  parameter int unsigned MAX_PULSE_NS = 2_500_000,
  parameter int unsigned LOST_MS      = 50
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         srv_i,
  output logic [N-1:0] position_o,
  output logic         valid_o,
  output logic         err_o,
  output logic         lost_o
);

  localparam int unsigned MS_CYC   = ms_cyc(CLK_PER_NS);
  localparam int unsigned STEP_CYC = step_cyc(STEP_NS, CLK_PER_NS);
  localparam int unsigned MIN_CYC  = ns_to_cyc(MIN_PULSE_NS, CLK_PER_NS);
  localparam int unsigned MAX_CYC  = ns_to_cyc(MAX_PULSE_NS, CLK_PER_NS);
  localparam int unsigned WW       = cnt_w(MAX_CYC);
  localparam int unsigned PW       = cnt_w(STEP_CYC - 1);
  localparam int unsigned MPW      = cnt_w(MS_CYC - 1);
  localparam int unsigned LW       = cnt_w(LOST_MS);

  localparam logic [WW-1:0]  MS_W      = WW'(MS_CYC);
  localparam logic [WW-1:0]  MIN_W     = WW'(MIN_CYC);
  localparam logic [WW-1:0]  MAX_LAST  = WW'(MAX_CYC - 1);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(STEP_CYC - 1);
  localparam logic [MPW-1:0] MS_LAST   = MPW'(MS_CYC - 1);
  localparam logic [LW-1:0]  LOST_LAST = LW'(LOST_MS - 1);
  localparam logic [N-1:0]   CODE_MAX  = {N{1'b1}};

  logic lvl, rise, fall;

  servo_input_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .srv_i   (srv_i),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e         state_q, state_d;
  logic [WW-1:0]  width_q, width_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [N-1:0]   step_q, step_d;
  logic [N-1:0]   pos_q, pos_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [MPW-1:0] ms_pre_q, ms_pre_d;
  logic [LW-1:0]  ms_cnt_q, ms_cnt_d;
  logic           lost_q, lost_d;

  // width_q counts high cycles including the rise cycle, so at the fall it equals the full width.
  // step_q tracks (width - MS_CYC) / STEP_CYC, saturating, once width passes one millisecond.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    pre_d   = pre_q;
    step_d  = step_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (!en_i) begin
      state_d = S_ARM;
      width_d = '0;
      pre_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_ARM: begin
          if (!lvl) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (rise) begin
            width_d = WW'(1);
            pre_d   = '0;
            step_d  = '0;
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d = S_WAIT;
            if (width_q >= MIN_W) begin
              valid_d = 1'b1;
              pos_d   = (width_q >= MS_W) ? step_q : '0;
            end
          end else if (width_q >= MAX_LAST) begin
            err_d   = 1'b1;
            state_d = S_ARM;
          end else begin
            width_d = width_q + 1'b1;
            if (width_q >= MS_W) begin
              if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (step_q != CODE_MAX) step_d = step_q + 1'b1;
              end else begin
                pre_d = pre_q + 1'b1;
              end
            end
          end
        end
        default: state_d = S_ARM;
      endcase
    end
  end

  always_comb begin
    ms_pre_d = ms_pre_q;
    ms_cnt_d = ms_cnt_q;
    lost_d   = lost_q;
    if (!en_i) begin
      ms_pre_d = '0;
      ms_cnt_d = '0;
      lost_d   = 1'b1;
    end else if (valid_d) begin
      ms_pre_d = '0;
      ms_cnt_d = '0;
      lost_d   = 1'b0;
    end else if (!lost_q) begin
      if (ms_pre_q == MS_LAST) begin
        ms_pre_d = '0;
        ms_cnt_d = ms_cnt_q + 1'b1;
        if (ms_cnt_q == LOST_LAST) lost_d = 1'b1;
      end else begin
        ms_pre_d = ms_pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_ARM;
      width_q  <= '0;
      pre_q    <= '0;
      step_q   <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ms_pre_q <= '0;
      ms_cnt_q <= '0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ms_pre_q <= ms_pre_d;
      ms_cnt_q <= ms_cnt_d;
      lost_q   <= lost_d;
    end
  end

  assign position_o = pos_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign lost_o     = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder at CLK_PER_NS=2000:
// MS_CYC=500, STEP_CYC=2, MIN_CYC=250, MAX_CYC=1250, LOST_MS=50 (25000 cycles).
module tb_servo_pulse_decoder;

  localparam int N = 8;
  localparam int LOST_CYC = 25000;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         en_i = 1'b1;
  logic         srv_i = 1'b0;
  logic [N-1:0] position_o;
  logic         valid_o, err_o, lost_o;

  servo_pulse_decoder #(
    .CLK_PER_NS   (2000),
    .N            (N),
    .STEP_NS      (4000),
    .MIN_PULSE_NS (500_000),
    .MAX_PULSE_NS (2_500_000),
    .LOST_MS      (50)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .srv_i      (srv_i),
    .position_o (position_o),
    .valid_o    (valid_o),
    .err_o      (err_o),
    .lost_o     (lost_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit is_err;
    int pos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_pos = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_valid(input int p);
    exp_t e;
    e.is_err = 1'b0;
    e.pos    = p;
    exp_q.push_back(e);
    cur_pos = p;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.pos    = cur_pos;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input int hi, input int lo);
    srv_i = 1'b1;
    repeat (hi) @(negedge clk_i);
    srv_i = 1'b0;
    repeat (lo) @(negedge clk_i);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (valid_o || err_o) begin
      if (valid_o) last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, err_o, valid_o}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_err", int'(err_o), int'(e.is_err));
        chk("strobe_kind_valid", int'(valid_o), int'(!e.is_err));
        chk(e.is_err ? "position_held_on_err" : "position", int'(position_o), e.pos);
        if (valid_o) chk("lost_cleared_with_valid", int'(lost_o), 0);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk_i);
    chk("reset_position", int'(position_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_err", int'(err_o), 0);
    chk("reset_lost", int'(lost_o), 1);
    rst_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("idle_lost", int'(lost_o), 1);

    expect_valid(125); pulse(750, 40);   // 1.5 ms
    chk("lost_after_valid", int'(lost_o), 0);
    expect_valid(0);   pulse(500, 40);   // 1.0 ms
    expect_valid(0);   pulse(400, 40);   // 0.8 ms
    expect_valid(255); pulse(1100, 40);  // 2.2 ms -> 300 saturates
    expect_err();      pulse(1500, 40);  // 3.0 ms
    expect_valid(125); pulse(750, 40);
    pulse(100, 40);                      // 0.2 ms glitch, discarded
    pulse(249, 40);                      // just under MIN
    expect_valid(0);   pulse(250, 40);   // exactly MIN
    expect_valid(125); pulse(751, 40);
    expect_valid(126); pulse(752, 40);
    expect_valid(255); pulse(1010, 40);  // exact top code
    expect_valid(255); pulse(1249, 40);  // longest valid pulse
    expect_err();      pulse(1250, 40);  // reaches MAX
    pulse(2, 40);                        // short spike, never a strobe

    chk("queue_drained_before_lost", exp_q.size(), 0);
    chk("lost_not_cleared_by_err", int'(lost_o), 0);
    while (cyc < last_valid_cyc + LOST_CYC - 5) @(negedge clk_i);
    chk("lost_before_50ms", int'(lost_o), 0);
    repeat (10) @(negedge clk_i);
    chk("lost_after_50ms", int'(lost_o), 1);

    // Reset while srv_i is high: that pulse is skipped.
    srv_i = 1'b1;
    repeat (5) @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("midpulse_reset_position", int'(position_o), 0);
    rst_n_i = 1'b1;
    cur_pos = 0;
    repeat (700) @(negedge clk_i);
    srv_i = 1'b0;
    repeat (40) @(negedge clk_i);
    expect_valid(50); pulse(600, 40);    // 1.2 ms

    // en_i rises while srv_i is high: that pulse is skipped.
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("disabled_lost", int'(lost_o), 1);
    srv_i = 1'b1;
    repeat (10) @(negedge clk_i);
    en_i = 1'b1;
    repeat (700) @(negedge clk_i);
    chk("disabled_position_held", int'(position_o), 50);
    srv_i = 1'b0;
    repeat (40) @(negedge clk_i);
    expect_valid(50); pulse(600, 40);

    repeat (20) @(negedge clk_i);
    chk("queue_drained_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
